// File: rtl/leaf_instr_loader.sv
// Streams an instruction image into one BFT leaf as addressed byte packets,
// then sends the ap_start command packet and pulses done.
module leaf_instr_loader #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 3,
    parameter int NUM_PORT_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [23:0]              num_bytes,
    input  logic [7:0]               din_byte,
    input  logic                     vld_byte,
    output logic                     ack_byte,
    output logic [PACKET_BITS-1:0]   dout_loader2bft,
    input  logic                     resend,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND_START, FINISH} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUM_LEAF_BITS-1:0] r_leaf;
    logic [NUM_LEAF_BITS-1:0] w_leaf_nxt;
    logic [23:0]              r_num_bytes;
    logic [23:0]              w_num_bytes_nxt;
    logic [23:0]              r_addr;
    logic [23:0]              w_addr_nxt;
    logic                     r_start_sent;
    logic                     w_start_sent_nxt;
    logic [PACKET_BITS-1:0]   r_dout;
    logic [PACKET_BITS-1:0]   w_dout_nxt;
    logic                     w_ack;

    function automatic logic [PACKET_BITS-1:0] f_pack(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        logic [PACKET_BITS-1:0] pkt;
        pkt = {PACKET_BITS{1'b0}};
        pkt[PACKET_BITS-1] = 1'b1;
        pkt[PACKET_BITS-2 -: NUM_LEAF_BITS] = leaf;
        pkt[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] = port;
        pkt[PAYLOAD_BITS-1:0] = payload;
        return pkt;
    endfunction

    // Next-state and datapath; resend freezes everything, including the packet on the bus
    always_comb begin
        w_state_nxt      = r_state;
        w_leaf_nxt       = r_leaf;
        w_num_bytes_nxt  = r_num_bytes;
        w_addr_nxt       = r_addr;
        w_start_sent_nxt = r_start_sent;
        w_dout_nxt       = r_dout;
        w_ack            = 1'b0;
        if (!resend) begin
            case (r_state)
                IDLE: begin
                    w_dout_nxt = {PACKET_BITS{1'b0}};
                    if (start) begin
                        w_leaf_nxt       = dest_leaf;
                        w_num_bytes_nxt  = num_bytes;
                        w_addr_nxt       = 24'd0;
                        w_start_sent_nxt = 1'b0;
                        w_state_nxt      = (num_bytes == 24'd0) ? SEND_START : LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                LOAD: begin
                    if (vld_byte) begin
                        w_ack      = 1'b1;
                        w_dout_nxt = f_pack(r_leaf, NUM_PORT_BITS'(1),
                                            PAYLOAD_BITS'({din_byte, r_addr}));
                        // The last byte does not advance addr, so 24'hFFFFFF never wraps
                        if (r_addr == r_num_bytes - 24'd1) begin
                            w_state_nxt = SEND_START;
                        end else begin
                            w_addr_nxt = r_addr + 24'd1;
                        end
                    end else begin
                        w_dout_nxt = {PACKET_BITS{1'b0}};
                    end
                end
                SEND_START: begin
                    if (r_start_sent) begin
                        w_dout_nxt  = {PACKET_BITS{1'b0}};
                        w_state_nxt = FINISH;
                    end else begin
                        w_dout_nxt       = f_pack(r_leaf, NUM_PORT_BITS'(0), PAYLOAD_BITS'(32'h0000_0001));
                        w_start_sent_nxt = 1'b1;
                    end
                end
                FINISH: begin
                    w_dout_nxt  = {PACKET_BITS{1'b0}};
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_dout_nxt  = {PACKET_BITS{1'b0}};
                    w_state_nxt = IDLE;
                end
            endcase
        end else begin
            w_ack = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_leaf       <= {NUM_LEAF_BITS{1'b0}};
            r_num_bytes  <= 24'd0;
            r_addr       <= 24'd0;
            r_start_sent <= 1'b0;
            r_dout       <= {PACKET_BITS{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_leaf       <= w_leaf_nxt;
            r_num_bytes  <= w_num_bytes_nxt;
            r_addr       <= w_addr_nxt;
            r_start_sent <= w_start_sent_nxt;
            r_dout       <= w_dout_nxt;
        end
    end

    assign dout_loader2bft = r_dout;
    assign ack_byte        = w_ack & ~reset;
    assign busy            = (r_state != IDLE) & ~reset;
    // A frozen FINISH cycle must not stretch the done pulse
    assign done            = (r_state == FINISH) & ~resend & ~reset;

endmodule

// File: tb/tb_leaf_instr_loader.sv
// Directed per-cycle vectors for leaf_instr_loader: inputs applied after the
// falling edge, outputs compared 1 ns later, before the next rising edge.
module tb_leaf_instr_loader;

    logic        clk = 1'b0;
    logic        reset, start, vld_byte, resend;
    logic [2:0]  dest_leaf;
    logic [23:0] num_bytes;
    logic [7:0]  din_byte;
    logic        ack_byte, busy, done;
    logic [48:0] dout_loader2bft;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [48:0] ZERO = 49'd0;

    typedef struct {
        logic        rst;
        logic        st;
        logic [2:0]  lf;
        logic [23:0] nb;
        logic [7:0]  db;
        logic        vb;
        logic        rs;
        logic        e_ack;
        logic [48:0] e_dout;
        logic        e_busy;
        logic        e_done;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    leaf_instr_loader dut (
        .clk(clk), .reset(reset), .start(start), .dest_leaf(dest_leaf),
        .num_bytes(num_bytes), .din_byte(din_byte), .vld_byte(vld_byte),
        .ack_byte(ack_byte), .dout_loader2bft(dout_loader2bft),
        .resend(resend), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference packet: valid bit 48, leaf 47:45, port 44:41, payload 31:0
    function automatic logic [48:0] pkt(input logic [2:0] lf, input logic [3:0] pt, input logic [31:0] pl);
        logic [48:0] p;
        p = 49'd0;
        p[48] = 1'b1;
        p[47:45] = lf;
        p[44:41] = pt;
        p[31:0] = pl;
        return p;
    endfunction

    function automatic vec_t mk(input logic rst, st, input logic [2:0] lf, input logic [23:0] nb,
                                input logic [7:0] db, input logic vb, rs, e_ack,
                                input logic [48:0] e_dout, input logic e_busy, e_done, input string nm);
        vec_t v;
        v.rst = rst; v.st = st; v.lf = lf; v.nb = nb; v.db = db; v.vb = vb; v.rs = rs;
        v.e_ack = e_ack; v.e_dout = e_dout; v.e_busy = e_busy; v.e_done = e_done; v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [48:0] got, input logic [48:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input vec_t v);
        @(negedge clk);
        reset = v.rst; start = v.st; dest_leaf = v.lf; num_bytes = v.nb;
        din_byte = v.db; vld_byte = v.vb; resend = v.rs;
        #1;
        chk({v.nm, ".ack"},  {48'd0, ack_byte}, {48'd0, v.e_ack});
        chk({v.nm, ".dout"}, dout_loader2bft,   v.e_dout);
        chk({v.nm, ".busy"}, {48'd0, busy},     {48'd0, v.e_busy});
        chk({v.nm, ".done"}, {48'd0, done},     {48'd0, v.e_done});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dest_leaf = 3'd0; num_bytes = 24'd0;
        din_byte = 8'd0; vld_byte = 1'b0; resend = 1'b0;
        repeat (2) @(negedge clk);
        cyc(mk(1'b1, 1'b0, 3'd0, 24'd0, 8'h00, 1'b0, 1'b0, 1'b0, ZERO, 1'b0, 1'b0, "reset"));

        // Continuous stream of four bytes to leaf 3
        tbl.push_back(mk(0, 1, 3'd3, 24'd4, 8'h00, 0, 0, 0, ZERO, 0, 0, "s_start"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h13, 1, 0, 1, ZERO, 1, 0, "s_b0"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 1, 0, 1, pkt(3'd3, 4'd1, 32'h1300_0000), 1, 0, "s_b1"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 1, 0, 1, pkt(3'd3, 4'd1, 32'h0000_0001), 1, 0, "s_b2"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 1, 0, 1, pkt(3'd3, 4'd1, 32'h0000_0002), 1, 0, "s_b3"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 0, 0, 0, pkt(3'd3, 4'd1, 32'h0000_0003), 1, 0, "s_last"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 0, 0, 0, pkt(3'd3, 4'd0, 32'h0000_0001), 1, 0, "s_cmd"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 0, 0, 0, ZERO, 1, 1, "s_done"));
        tbl.push_back(mk(0, 0, 3'd3, 24'd4, 8'h00, 0, 0, 0, ZERO, 0, 0, "s_idle"));
        // Resend held two cycles on byte 2, then once on the start packet
        tbl.push_back(mk(0, 1, 3'd2, 24'd4, 8'h00, 0, 0, 0, ZERO, 0, 0, "r_start"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'hA0, 1, 0, 1, ZERO, 1, 0, "r_b0"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'hA1, 1, 0, 1, pkt(3'd2, 4'd1, 32'hA000_0000), 1, 0, "r_b1"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'hA2, 1, 0, 1, pkt(3'd2, 4'd1, 32'hA100_0001), 1, 0, "r_b2"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'hA3, 1, 1, 0, pkt(3'd2, 4'd1, 32'hA200_0002), 1, 0, "r_hold1"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'hA3, 1, 1, 0, pkt(3'd2, 4'd1, 32'hA200_0002), 1, 0, "r_hold2"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'hA3, 1, 0, 1, pkt(3'd2, 4'd1, 32'hA200_0002), 1, 0, "r_b3"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'h00, 0, 0, 0, pkt(3'd2, 4'd1, 32'hA300_0003), 1, 0, "r_last"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'h00, 0, 1, 0, pkt(3'd2, 4'd0, 32'h0000_0001), 1, 0, "r_cmd_rej"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'h00, 0, 0, 0, pkt(3'd2, 4'd0, 32'h0000_0001), 1, 0, "r_cmd_acc"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'h00, 0, 0, 0, ZERO, 1, 1, "r_done"));
        tbl.push_back(mk(0, 0, 3'd2, 24'd4, 8'h00, 0, 0, 0, ZERO, 0, 0, "r_idle"));
        // Zero-length image: start packet only; offered byte is not acked
        tbl.push_back(mk(0, 1, 3'd5, 24'd0, 8'h00, 0, 0, 0, ZERO, 0, 0, "z_start"));
        tbl.push_back(mk(0, 0, 3'd5, 24'd0, 8'h55, 1, 0, 0, ZERO, 1, 0, "z_send"));
        tbl.push_back(mk(0, 0, 3'd5, 24'd0, 8'h00, 0, 0, 0, pkt(3'd5, 4'd0, 32'h0000_0001), 1, 0, "z_cmd"));
        tbl.push_back(mk(0, 0, 3'd5, 24'd0, 8'h00, 0, 0, 0, ZERO, 1, 1, "z_done"));
        tbl.push_back(mk(0, 0, 3'd5, 24'd0, 8'h00, 0, 0, 0, ZERO, 0, 0, "z_idle"));
        // Start pulses while busy carry a different leaf and length and must be ignored
        tbl.push_back(mk(0, 1, 3'd1, 24'd2, 8'h00, 0, 0, 0, ZERO, 0, 0, "b_start"));
        tbl.push_back(mk(0, 1, 3'd7, 24'd9, 8'h11, 1, 0, 1, ZERO, 1, 0, "b_b0"));
        tbl.push_back(mk(0, 0, 3'd7, 24'd9, 8'h22, 1, 0, 1, pkt(3'd1, 4'd1, 32'h1100_0000), 1, 0, "b_b1"));
        tbl.push_back(mk(0, 1, 3'd7, 24'd9, 8'h33, 1, 0, 0, pkt(3'd1, 4'd1, 32'h2200_0001), 1, 0, "b_last"));
        tbl.push_back(mk(0, 0, 3'd7, 24'd9, 8'h00, 0, 0, 0, pkt(3'd1, 4'd0, 32'h0000_0001), 1, 0, "b_cmd"));
        tbl.push_back(mk(0, 0, 3'd7, 24'd9, 8'h00, 0, 0, 0, ZERO, 1, 1, "b_done"));
        tbl.push_back(mk(0, 0, 3'd7, 24'd9, 8'h00, 0, 0, 0, ZERO, 0, 0, "b_idle"));

        foreach (tbl[i]) cyc(tbl[i]);

        // Three-cycle vld gaps between bytes: zero packets in gaps, contiguous addresses
        cyc(mk(0, 1, 3'd4, 24'd3, 8'h00, 0, 0, 0, ZERO, 0, 0, "g_start"));
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            b = 8'h31 + 8'(k);
            cyc(mk(0, 0, 3'd4, 24'd3, b, 1, 0, 1, ZERO, 1, 0, "g_byte"));
            cyc(mk(0, 0, 3'd4, 24'd3, 8'h00, 0, 0, 0, pkt(3'd4, 4'd1, {b, 24'(k)}), 1, 0, "g_pkt"));
            if (k < 2) begin
                cyc(mk(0, 0, 3'd4, 24'd3, 8'h00, 0, 0, 0, ZERO, 1, 0, "g_gap1"));
                cyc(mk(0, 0, 3'd4, 24'd3, 8'h00, 0, 0, 0, ZERO, 1, 0, "g_gap2"));
            end
        end
        cyc(mk(0, 0, 3'd4, 24'd3, 8'h00, 0, 0, 0, pkt(3'd4, 4'd0, 32'h0000_0001), 1, 0, "g_cmd"));
        cyc(mk(0, 0, 3'd4, 24'd3, 8'h00, 0, 0, 0, ZERO, 1, 1, "g_done"));

        // Reset after two of eight bytes, then reset together with start, then a clean job
        cyc(mk(0, 1, 3'd6, 24'd8, 8'h00, 0, 0, 0, ZERO, 0, 0, "x_start"));
        cyc(mk(0, 0, 3'd6, 24'd8, 8'h61, 1, 0, 1, ZERO, 1, 0, "x_b0"));
        cyc(mk(0, 0, 3'd6, 24'd8, 8'h62, 1, 0, 1, pkt(3'd6, 4'd1, 32'h6100_0000), 1, 0, "x_b1"));
        cyc(mk(1, 0, 3'd6, 24'd8, 8'h63, 1, 0, 0, pkt(3'd6, 4'd1, 32'h6200_0001), 0, 0, "x_reset"));
        cyc(mk(1, 1, 3'd6, 24'd8, 8'h00, 0, 1, 0, ZERO, 0, 0, "x_rst_start"));
        for (int k = 0; k < 4; k++)
            cyc(mk(0, 0, 3'd6, 24'd8, 8'h64, 1, 0, 0, ZERO, 0, 0, "x_quiet"));
        cyc(mk(0, 1, 3'd6, 24'd1, 8'h00, 0, 0, 0, ZERO, 0, 0, "x2_start"));
        cyc(mk(0, 0, 3'd6, 24'd1, 8'h7F, 1, 0, 1, ZERO, 1, 0, "x2_b0"));
        cyc(mk(0, 0, 3'd6, 24'd1, 8'h00, 0, 0, 0, pkt(3'd6, 4'd1, 32'h7F00_0000), 1, 0, "x2_pkt"));
        cyc(mk(0, 0, 3'd6, 24'd1, 8'h00, 0, 0, 0, pkt(3'd6, 4'd0, 32'h0000_0001), 1, 0, "x2_cmd"));
        cyc(mk(0, 0, 3'd6, 24'd1, 8'h00, 0, 0, 0, ZERO, 1, 1, "x2_done"));
        cyc(mk(0, 0, 3'd6, 24'd1, 8'h00, 0, 0, 0, ZERO, 0, 0, "x2_idle"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
